mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Memory-side responder for the S8SP address/data path.
- Accepts the address driven by the address register (ar_on_bus), a write-data byte, and read/write strobes from the control unit.
- Performs the access on an internal 2^ADDR_W x DATA_W array after a programmable number of wait states, then returns a one-cycle completion pulse and, for reads, a registered data byte.

Parameters:
- ADDR_W, 8, address width; array depth is 2^ADDR_W.
- DATA_W, 8, data width.
- WAIT_CYC, 2, wait states between request acceptance and completion; legal range 0..15.
- WPROT_BASE, 8'hF0, lowest write-protected address. Used only with MEM_WPROT_EN.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- mem_addr  input  ADDR_W  access address, driven from ar_on_bus.
- mem_wdata  input  DATA_W  write data.
- mem_rd  input  1  read request level.
- mem_wr  input  1  write request level.
- mem_rdata  output  DATA_W  registered read data.
- mem_busy  output  1  high while a transaction is in progress.
- mem_done  output  1  one-cycle completion pulse.
- mem_err  output  1  error qualifier, valid only while mem_done=1.

Behaviour:
- Reset (async, any state): state=IDLE, wait counter=0, mem_rdata=0, mem_busy=0, mem_done=0, mem_err=0. Array contents are not reset and are retained across reset.
- States: IDLE, WAIT, DONE. mem_busy=1 in WAIT and DONE. mem_done=1 only in DONE. All outputs are registered.
- IDLE, request accepted at edge E0 when mem_rd^mem_wr=1:
  - Capture mem_addr, mem_wdata and the direction.
  - If WAIT_CYC=0, go to DONE. Otherwise go to WAIT with counter=WAIT_CYC-1.
- WAIT: counter decrements each edge. On the edge where counter=0, go to DONE.
- The array access happens on the edge entering DONE:
  - Write: array[addr] <= captured wdata.
  - Read: mem_rdata <= array[addr].
- Latency: mem_done is high during the cycle after edge E0+WAIT_CYC, for exactly one cycle. Then the block returns to IDLE.
- Collision: mem_rd=mem_wr=1 in IDLE. Go directly to DONE with mem_err=1. No array access. mem_rdata unchanged.
- Requests in WAIT and DONE are ignored; captured address and data are not re-sampled.
- Requester protocol: hold the request until mem_done, then deassert in the mem_done cycle. A request still high in IDLE after DONE is treated as a new transaction.
- mem_rdata holds its value until the next completed read. Writes and errors do not change it.
- Reset before the edge entering DONE aborts the transaction: no array write and no mem_done.
- Address arithmetic is none. 8'hFF and 8'h00 are independent locations; there is no wrap or aliasing.

Optional Feature:
- Macro MEM_WPROT_EN.
- Defined: a write with captured address >= WPROT_BASE completes with normal latency, mem_done=1 and mem_err=1, and the array is not modified. Reads of protected addresses are unaffected.
- Undefined: all writes commit, and mem_err is asserted only on collision.

Decomposition:
- Package s8sp_mem_pkg holds:
  - State encoding constants ST_IDLE=2'd0, ST_WAIT=2'd1, ST_DONE=2'd2.
  - Default widths ADDR_W_DEF=8 and DATA_W_DEF=8.
- One sub-module, mem_array: synchronous write, registered read port, no reset, parameterised by ADDR_W and DATA_W, instantiated once. The FSM, counter and error logic stay in mem_responder.

Test Plan (all with WAIT_CYC=2 unless noted):
1. Reset mid-idle with random inputs -> mem_rdata=8'h00, mem_busy=0, mem_done=0, mem_err=0 immediately, asynchronously, before the next clk edge.
2. Write 8'hA5 to 8'h10, then read 8'h10 -> mem_done high in the 3rd cycle after the accept edge, mem_err=0, mem_rdata=8'hA5.
3. Write 8'h11 to 8'hFF and 8'h22 to 8'h00, read both -> 8'h11 and 8'h22 respectively; no aliasing. Repeat with WAIT_CYC=0 -> mem_done in the cycle right after accept.
4. Read 8'h10 accepted; while busy, drive mem_wr=1, mem_addr=8'h10, mem_wdata=8'h00 -> ignored; mem_rdata=8'hA5 and a later read still returns 8'hA5.
5. mem_rd=mem_wr=1 in IDLE at 8'h10 with wdata 8'h3C -> mem_done and mem_err high the next cycle; mem_rdata unchanged; a later read returns 8'hA5. Separately, assert reset during WAIT of a write 8'h77 to 8'h10 -> no mem_done, and a later read returns 8'hA5.
6. With MEM_WPROT_EN: write 8'h5A to 8'hF5 -> mem_done=1, mem_err=1, and a later read returns the prior value; write 8'h5A to 8'hEF -> mem_err=0 and a read returns 8'h5A.

Source files
------------

// File: rtl/s8sp_mem_pkg.sv
// Shared constants for the S8SP memory responder: FSM state encoding and default widths.
package s8sp_mem_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

endpackage

// File: rtl/mem_array.sv
// Single-port storage array: synchronous write and an enabled, registered read port.
module mem_array
    import s8sp_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_rdata;

    // NOTE: storage has no reset, so it maps onto RAM and its contents survive a reset.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_addr] <= i_wdata;
        end
        if (i_rd_en) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// S8SP memory-side responder: accepts one read or write, waits WAIT_CYC cycles, then pulses mem_done.
// Optional write protection of addresses >= WPROT_BASE is enabled by defining MEM_WPROT_EN.
module mem_responder
    import s8sp_mem_pkg::*;
#(
    parameter int                ADDR_W     = ADDR_W_DEF,
    parameter int                DATA_W     = DATA_W_DEF,
    parameter int                WAIT_CYC   = 2,
    parameter logic [ADDR_W-1:0] WPROT_BASE = ADDR_W'(8'hF0)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_rd,
    input  logic              mem_wr,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_busy,
    output logic              mem_done,
    output logic              mem_err
);

    localparam logic [3:0] CNT_INIT = (WAIT_CYC == 0) ? 4'd0 : 4'(WAIT_CYC - 1);
`ifdef MEM_WPROT_EN
    localparam logic WPROT_ON = 1'b1;
`else
    localparam logic WPROT_ON = 1'b0;
`endif

    logic [1:0]        r_state;
    logic [3:0]        r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_is_wr;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic              r_rd_valid;

    logic [1:0]        w_next_state;
    logic [3:0]        w_next_cnt;
    logic              w_enter_done;
    logic              w_idle;
    logic              w_collide;
    logic [ADDR_W-1:0] w_acc_addr;
    logic [DATA_W-1:0] w_acc_wdata;
    logic              w_acc_wr;
    logic              w_prot_hit;
    logic              w_arr_we;
    logic              w_arr_re;
    logic [DATA_W-1:0] w_arr_rdata;

    assign w_idle    = (r_state == ST_IDLE);
    assign w_collide = mem_rd & mem_wr;

    // With zero wait states the access happens on the accept edge, before the capture registers load.
    assign w_acc_addr  = w_idle ? mem_addr  : r_addr;
    assign w_acc_wdata = w_idle ? mem_wdata : r_wdata;
    assign w_acc_wr    = w_idle ? mem_wr    : r_is_wr;

    assign w_prot_hit = WPROT_ON && w_acc_wr && (w_acc_addr >= WPROT_BASE);
    assign w_arr_we   = w_enter_done && w_acc_wr && !w_prot_hit;
    assign w_arr_re   = w_enter_done && !w_acc_wr;

    // NOTE: every signal gets a default first so no path through the case leaves a latch.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_enter_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_collide) begin
                    w_next_state = ST_DONE;
                end else if (mem_rd ^ mem_wr) begin
                    if (WAIT_CYC == 0) begin
                        w_next_state = ST_DONE;
                        w_enter_done = 1'b1;
                    end else begin
                        w_next_state = ST_WAIT;
                        w_next_cnt   = CNT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_next_state = ST_DONE;
                    w_enter_done = 1'b1;
                end else begin
                    w_next_cnt = r_cnt - 4'd1;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 4'd0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_is_wr    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_rd_valid <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            r_busy  <= (w_next_state != ST_IDLE);
            r_done  <= (w_next_state == ST_DONE);
            r_err   <= (w_idle && w_collide) || (w_enter_done && w_prot_hit);
            if (w_idle && (mem_rd || mem_wr)) begin
                r_addr  <= mem_addr;
                r_wdata <= mem_wdata;
                r_is_wr <= mem_wr;
            end
            if (w_arr_re) begin
                r_rd_valid <= 1'b1;
            end
        end
    end

    mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk     (clk),
        .i_wr_en (w_arr_we),
        .i_rd_en (w_arr_re),
        .i_addr  (w_acc_addr),
        .i_wdata (w_acc_wdata),
        .o_rdata (w_arr_rdata)
    );

    // The array's read register has no reset; it reads as zero until a read completes after reset.
    assign mem_rdata = r_rd_valid ? w_arr_rdata : '0;
    assign mem_busy  = r_busy;
    assign mem_done  = r_done;
    assign mem_err   = r_err;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (WAIT_CYC=2 and WAIT_CYC=0) checked against an array model.
module tb_mem_responder;

`ifdef MEM_WPROT_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       sel;
    logic [7:0] t_addr, t_wdata;
    logic       t_rd, t_wr;

    logic       a_rd, a_wr, b_rd, b_wr;
    logic [7:0] a_rdata, b_rdata, o_rdata;
    logic       a_busy, a_done, a_err, b_busy, b_done, b_err;
    logic       o_busy, o_done, o_err;

    assign a_rd = !sel ? t_rd : 1'b0;
    assign a_wr = !sel ? t_wr : 1'b0;
    assign b_rd =  sel ? t_rd : 1'b0;
    assign b_wr =  sel ? t_wr : 1'b0;
    assign o_rdata = sel ? b_rdata : a_rdata;
    assign o_busy  = sel ? b_busy  : a_busy;
    assign o_done  = sel ? b_done  : a_done;
    assign o_err   = sel ? b_err   : a_err;

    mem_responder #(.ADDR_W(8), .DATA_W(8), .WAIT_CYC(2), .WPROT_BASE(8'hF0)) u_dut2 (
        .clk(clk), .reset(reset), .mem_addr(t_addr), .mem_wdata(t_wdata),
        .mem_rd(a_rd), .mem_wr(a_wr), .mem_rdata(a_rdata), .mem_busy(a_busy),
        .mem_done(a_done), .mem_err(a_err)
    );

    mem_responder #(.ADDR_W(8), .DATA_W(8), .WAIT_CYC(0), .WPROT_BASE(8'hF0)) u_dut0 (
        .clk(clk), .reset(reset), .mem_addr(t_addr), .mem_wdata(t_wdata),
        .mem_rd(b_rd), .mem_wr(b_wr), .mem_rdata(b_rdata), .mem_busy(b_busy),
        .mem_done(b_done), .mem_err(b_err)
    );

    // Reference model: one array and one read-data holding register per instance.
    logic [7:0] m_mem   [2][256];
    bit         m_vld   [2][256];
    logic [7:0] m_rdata [2];

    int n_vec = 0;
    int n_err = 0;

    // One complete transaction, with expected latency, error and data taken from the model.
    task automatic txn(input bit s, input logic rd, input logic wr, input logic [7:0] addr,
                       input logic [7:0] wdata, input bit meddle, input string name);
        bit exp_err;
        int exp_lat;
        int n;
        bit seen;
        exp_err = (rd && wr) || (wr && !rd && PROT && (addr >= 8'hF0));
        exp_lat = (rd && wr) ? 1 : (s ? 0 : 2) + 1;
        @(negedge clk);
        sel = s; t_rd = rd; t_wr = wr; t_addr = addr; t_wdata = wdata;
        n = 0; seen = 0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (o_done === 1'b1) begin
                seen = 1;
            end else begin
                n_vec++;
                if (o_busy !== 1'b1) begin
                    n_err++;
                    $display("FAIL %s busy_wait cyc%0d: got %b want 1", name, n, o_busy);
                end
                if (meddle) begin
                    t_wr = 1'b1; t_addr = addr; t_wdata = 8'h00;
                end
            end
        end
        t_rd = 1'b0; t_wr = 1'b0;
        n_vec++;
        if (!seen || n != exp_lat) begin
            n_err++;
            $display("FAIL %s latency: got %0d cycles (seen=%0b) want %0d", name, n, seen, exp_lat);
        end
        if (!exp_err) begin
            if (wr) begin
                m_mem[s][addr] = wdata;
                m_vld[s][addr] = 1'b1;
            end else begin
                m_rdata[s] = m_mem[s][addr];
            end
        end
        if (seen) begin
            n_vec++;
            if (o_err !== exp_err || o_busy !== 1'b1) begin
                n_err++;
                $display("FAIL %s err/busy: got %b/%b want %b/1", name, o_err, o_busy, exp_err);
            end
            n_vec++;
            if (o_rdata !== m_rdata[s]) begin
                n_err++;
                $display("FAIL %s rdata: got %h want %h", name, o_rdata, m_rdata[s]);
            end
        end
        @(negedge clk);
        n_vec++;
        if (o_done !== 1'b0 || o_busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s after_done: done/busy got %b/%b want 0/0", name, o_done, o_busy);
        end
    endtask

    task automatic test_reset(input string name);
        @(negedge clk);
        sel = 1'($urandom_range(0, 1));
        t_rd = 1'($urandom); t_wr = 1'($urandom);
        t_addr = 8'($urandom); t_wdata = 8'($urandom);
        #2 reset = 1'b1;
        #1;
        n_vec++;
        if ({a_rdata, a_busy, a_done, a_err} !== 11'd0) begin
            n_err++;
            $display("FAIL %s dut2_async: got %h/%b%b%b want 00/000", name, a_rdata, a_busy, a_done, a_err);
        end
        n_vec++;
        if ({b_rdata, b_busy, b_done, b_err} !== 11'd0) begin
            n_err++;
            $display("FAIL %s dut0_async: got %h/%b%b%b want 00/000", name, b_rdata, b_busy, b_done, b_err);
        end
        repeat (2) begin
            @(negedge clk);
            t_rd = 1'($urandom); t_wr = 1'($urandom); t_addr = 8'($urandom);
        end
        t_rd = 1'b0; t_wr = 1'b0;
        reset = 1'b0;
        m_rdata[0] = 8'h00;
        m_rdata[1] = 8'h00;
        @(negedge clk);
        n_vec++;
        if (o_busy !== 1'b0 || o_done !== 1'b0 || o_rdata !== 8'h00) begin
            n_err++;
            $display("FAIL %s post_release: got busy=%b done=%b rdata=%h want 0/0/00", name, o_busy, o_done, o_rdata);
        end
    endtask

    task automatic test_write_read();
        txn(0, 0, 1, 8'h10, 8'hA5, 0, "wr_10");
        txn(0, 1, 0, 8'h10, 8'h00, 0, "rd_10");
    endtask

    task automatic test_no_alias(input bit s);
        txn(s, 0, 1, 8'hFF, 8'h11, 0, "wr_ff");
        txn(s, 0, 1, 8'h00, 8'h22, 0, "wr_00");
        txn(s, 1, 0, 8'hFF, 8'h00, 0, "rd_ff");
        txn(s, 1, 0, 8'h00, 8'h00, 0, "rd_00");
    endtask

    task automatic test_busy_ignore();
        txn(0, 1, 0, 8'h10, 8'h00, 1, "rd_meddled");
        txn(0, 1, 0, 8'h10, 8'h00, 0, "rd_after_meddle");
    endtask

    task automatic test_collision();
        txn(0, 1, 0, 8'hFF, 8'h00, 0, "rd_ff_pre");
        txn(0, 1, 1, 8'h10, 8'h3C, 0, "collide");
        txn(0, 1, 0, 8'h10, 8'h00, 0, "rd_after_collide");
    endtask

    task automatic test_reset_abort();
        @(negedge clk);
        sel = 1'b0; t_wr = 1'b1; t_rd = 1'b0; t_addr = 8'h10; t_wdata = 8'h77;
        @(negedge clk);
        n_vec++;
        if (a_busy !== 1'b1) begin
            n_err++;
            $display("FAIL abort busy_before_reset: got %b want 1", a_busy);
        end
        #1 reset = 1'b1;
        t_wr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_vec++;
            if (a_done !== 1'b0 || a_busy !== 1'b0) begin
                n_err++;
                $display("FAIL abort in_reset%0d: done/busy got %b/%b want 0/0", i, a_done, a_busy);
            end
        end
        reset = 1'b0;
        m_rdata[0] = 8'h00;
        m_rdata[1] = 8'h00;
        txn(0, 1, 0, 8'h10, 8'h00, 0, "rd_after_abort");
    endtask

    task automatic test_wprot();
        txn(0, 1, 0, 8'hF5, 8'h00, 0, "rd_f5_pre");
        txn(0, 0, 1, 8'hF5, 8'h5A, 0, "wr_f5");
        txn(0, 1, 0, 8'hF5, 8'h00, 0, "rd_f5");
        txn(0, 0, 1, 8'hEF, 8'h5A, 0, "wr_ef");
        txn(0, 1, 0, 8'hEF, 8'h00, 0, "rd_ef");
        txn(1, 0, 1, 8'hF0, 8'hC3, 0, "wr_f0_fast");
        txn(1, 1, 0, 8'hF0, 8'h00, 0, "rd_f0_fast");
    endtask

    task automatic test_random(input int count);
        bit s;
        int op;
        logic [7:0] addr;
        for (int i = 0; i < count; i++) begin
            s    = 1'($urandom_range(0, 1));
            op   = int'($urandom_range(0, 9));
            addr = 8'($urandom);
            if (op == 0) begin
                txn(s, 1, 1, addr, 8'($urandom), 0, "rnd_collide");
            end else if (op >= 5) begin
                for (int k = 0; k < 256 && !m_vld[s][addr]; k++) addr++;
                if (m_vld[s][addr]) txn(s, 1, 0, addr, 8'($urandom), 0, "rnd_rd");
                else                txn(s, 0, 1, addr, 8'($urandom), 0, "rnd_wr");
            end else begin
                txn(s, 0, 1, addr, 8'($urandom), 0, "rnd_wr");
            end
        end
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            for (int a = 0; a < 256; a++) begin
                m_mem[s][a] = 8'hxx;
                m_vld[s][a] = 1'b0;
            end
            m_rdata[s] = 8'h00;
        end
        sel = 1'b0; t_rd = 1'b0; t_wr = 1'b0; t_addr = 8'h00; t_wdata = 8'h00;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        test_reset("reset_por");
        test_write_read();
        test_reset("reset_loaded");
        txn(0, 1, 0, 8'h10, 8'h00, 0, "rd_retained");
        test_no_alias(0);
        test_no_alias(1);
        test_busy_ignore();
        test_collision();
        test_reset_abort();
        test_wprot();
        test_random(60);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
